vram_scanout: RTL and testbench

Display-side stage of the capture path: reads the 2-bit-per-pixel framebuffer that the LCD sampler writes and regenerates a 640x480@60 video stream. Each 160x144 source pixel is upscaled by 3 to 480x432, centred in the frame with a border colour, and mapped through a 4-entry palette. It owns the read port of the dual-port VRAM; the sampler owns the write port.

---
 rtl/vid_pkg.sv | 50 +++++
 rtl/vram_scanout_if.sv | 22 ++
 rtl/vid_timing.sv | 67 ++++++
 rtl/vram_scanout.sv | 182 ++++++++++++++++++
 tb/tb_vram_scanout.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vid_pkg.sv
// vid_pkg: shared video timing constants, derived totals
// and pixel/colour types for the display path.
package vid_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF
                           + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF
                           + V_SYNC_DEF + V_BP_DEF;

    localparam int SRC_W_DEF = 160;
    localparam int SRC_H_DEF = 144;
    localparam int SCALE_DEF = 3;
    localparam int X_OFS_DEF = 80;
    localparam int Y_OFS_DEF = 24;

    localparam int CNT_W   = 11;
    localparam int PIX_W   = 2;
    localparam int COORD_W = 8;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [PIX_W-1:0]   pix_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [1:0]         sub_t;
    typedef logic [11:0]        rgb12_t;

    function automatic rgb12_t pal_lookup(
        input logic [47:0] pal,
        input pix_t        idx
    );
        rgb12_t c;
        c = '0;
        unique case (idx)
            2'd0: c = pal[11:0];
            2'd1: c = pal[23:12];
            2'd2: c = pal[35:24];
            2'd3: c = pal[47:36];
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vram_scanout_if.sv
// vram_scanout_if: read port of the framebuffer VRAM.
// master = scanout, slave = memory.
interface vram_scanout_if;
    import vid_pkg::*;

    logic        vramclk;
    logic [15:0] vramaddr;
    pix_t        vramdata;

    modport master (
        output vramclk,
        output vramaddr,
        input  vramdata
    );

    modport slave (
        input  vramclk,
        input  vramaddr,
        output vramdata
    );

endinterface

// File: rtl/vid_timing.sv
// vid_timing: raster counters with active/sync decode,
// shareable by any display path.
module vid_timing
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic vid_clk,
    input  logic rst_n,
    output cnt_t hcnt_o,
    output cnt_t vcnt_o,
    output logic active_o,
    output logic hsync_o,
    output logic vsync_o,
    output logic line_end_o,
    output logic frame_end_o
);

    localparam cnt_t HMAX = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t VMAX = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam cnt_t HACT = cnt_t'(H_ACTIVE);
    localparam cnt_t VACT = cnt_t'(V_ACTIVE);
    localparam cnt_t HS0  = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS1  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS0  = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS1  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t hcnt_q, hcnt_d;
    cnt_t vcnt_q, vcnt_d;

    // Next raster position: wrap the line, then the frame.
    always_comb begin
        hcnt_d = hcnt_q + cnt_t'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == HMAX) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == VMAX) ? '0 : vcnt_q + cnt_t'(1);
        end
    end

    // Raster position registers.
    always_ff @(posedge vid_clk) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    assign hcnt_o      = hcnt_q;
    assign vcnt_o      = vcnt_q;
    assign active_o    = (hcnt_q < HACT) && (vcnt_q < VACT);
    assign hsync_o     = !((hcnt_q >= HS0) && (hcnt_q < HS1));
    assign vsync_o     = !((vcnt_q >= VS0) && (vcnt_q < VS1));
    assign line_end_o  = (hcnt_q == HMAX);
    assign frame_end_o = (hcnt_q == HMAX) && (vcnt_q == VMAX);

endmodule

// File: rtl/vram_scanout.sv
// vram_scanout: upscales the 2bpp framebuffer into a video
// stream with border and frame-latched palette.
module vram_scanout
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SRC_W    = SRC_W_DEF,
    parameter int SRC_H    = SRC_H_DEF,
    parameter int SCALE    = SCALE_DEF,
    parameter int X_OFS    = X_OFS_DEF,
    parameter int Y_OFS    = Y_OFS_DEF
) (
    input  logic           vid_clk,
    input  logic           rst_n,
    vram_scanout_if.master vram,
    input  logic [47:0]    pal,
    input  rgb12_t         border,
    output logic [3:0]     out_r,
    output logic [3:0]     out_g,
    output logic [3:0]     out_b,
    output logic           out_hsync,
    output logic           out_vsync,
    output logic           out_de,
    output logic           frame_start
);

    localparam cnt_t   XLO  = cnt_t'(X_OFS);
    localparam cnt_t   XHI  = cnt_t'(X_OFS + SRC_W * SCALE);
    localparam cnt_t   YLO  = cnt_t'(Y_OFS);
    localparam cnt_t   YHI  = cnt_t'(Y_OFS + SRC_H * SCALE);
    localparam sub_t   SMAX = sub_t'(SCALE - 1);
    localparam coord_t XMAX = coord_t'(SRC_W - 1);
    localparam coord_t YMAX = coord_t'(SRC_H - 1);

    cnt_t hcnt, vcnt;
    logic active, hsync, vsync, line_end, frame_end;

    vid_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP),
        .H_SYNC   (H_SYNC),   .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP),
        .V_SYNC   (V_SYNC),   .V_BP (V_BP)
    ) u_timing (
        .vid_clk     (vid_clk),
        .rst_n       (rst_n),
        .hcnt_o      (hcnt),
        .vcnt_o      (vcnt),
        .active_o    (active),
        .hsync_o     (hsync),
        .vsync_o     (vsync),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    logic hwin, vwin, inwin, origin;
    assign hwin   = (hcnt >= XLO) && (hcnt < XHI);
    assign vwin   = (vcnt >= YLO) && (vcnt < YHI);
    assign inwin  = active && hwin && vwin;
    assign origin = (hcnt == '0) && (vcnt == '0);

    sub_t   xsub_q, xsub_d, ysub_q, ysub_d;
    coord_t sx_q, sx_d, sy_q, sy_d;

    // Source coordinates by scale sub-counters; they saturate
    // at the image edge so the address holds past the window.
    always_comb begin
        xsub_d = xsub_q;
        sx_d   = sx_q;
        ysub_d = ysub_q;
        sy_d   = sy_q;
        if (inwin) begin
            if (xsub_q == SMAX) begin
                xsub_d = '0;
                if (sx_q != XMAX) sx_d = sx_q + coord_t'(1);
            end else begin
                xsub_d = xsub_q + sub_t'(1);
            end
        end
        if (line_end) begin
            xsub_d = '0;
            sx_d   = '0;
            if (vwin) begin
                if (ysub_q == SMAX) begin
                    ysub_d = '0;
                    if (sy_q != YMAX) sy_d = sy_q + coord_t'(1);
                end else begin
                    ysub_d = ysub_q + sub_t'(1);
                end
            end
        end
        if (frame_end) begin
            ysub_d = '0;
            sy_d   = '0;
        end
    end

    // Source coordinate registers double as the VRAM address.
    always_ff @(posedge vid_clk) begin
        if (!rst_n) begin
            xsub_q <= '0;
            sx_q   <= '0;
            ysub_q <= '0;
            sy_q   <= '0;
        end else begin
            xsub_q <= xsub_d;
            sx_q   <= sx_d;
            ysub_q <= ysub_d;
            sy_q   <= sy_d;
        end
    end

    assign vram.vramclk  = vid_clk;
    assign vram.vramaddr = {sy_q, sx_q};

    logic [47:0] pal_sh_q;
    rgb12_t      bord_sh_q;

    // Latch palette and border once per frame to avoid tearing.
    always_ff @(posedge vid_clk) begin
        if (!rst_n) begin
            pal_sh_q  <= '0;
            bord_sh_q <= '0;
        end else if (origin) begin
            pal_sh_q  <= pal;
            bord_sh_q <= border;
        end
    end

    logic   win1_q, act1_q, hs1_q, vs1_q, fs1_q;
    logic   de_q, hs_q, vs_q, fs_q;
    rgb12_t rgb_q, rgb_d;

    // Stage-2 colour select from the returned VRAM index.
    always_comb begin
        rgb_d = '0;
        if (win1_q) rgb_d = pal_lookup(pal_sh_q, vram.vramdata);
        else if (act1_q) rgb_d = bord_sh_q;
    end

    // Delay qualifiers alongside the VRAM read, register outputs.
    always_ff @(posedge vid_clk) begin
        if (!rst_n) begin
            win1_q <= 1'b0;
            act1_q <= 1'b0;
            hs1_q  <= 1'b1;
            vs1_q  <= 1'b1;
            fs1_q  <= 1'b0;
            rgb_q  <= '0;
            de_q   <= 1'b0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            fs_q   <= 1'b0;
        end else begin
            win1_q <= inwin;
            act1_q <= active;
            hs1_q  <= hsync;
            vs1_q  <= vsync;
            fs1_q  <= origin;
            rgb_q  <= rgb_d;
            de_q   <= act1_q;
            hs_q   <= hs1_q;
            vs_q   <= vs1_q;
            fs_q   <= fs1_q;
        end
    end

    assign out_r       = rgb_q[11:8];
    assign out_g       = rgb_q[7:4];
    assign out_b       = rgb_q[3:0];
    assign out_de      = de_q;
    assign out_hsync   = hs_q;
    assign out_vsync   = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vram_scanout.sv
// tb_vram_scanout: directed checks on a reduced-geometry
// instance plus a full 640x480 instance for address lines.
module tb_vram_scanout;

    localparam int SHT = 28;
    localparam int SFR = 448;
    localparam int FHT = 800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] pal;
    logic [11:0] border;

    always #5 clk = ~clk;

    vram_scanout_if vif_s ();
    vram_scanout_if vif_f ();

    logic [3:0] s_r, s_g, s_b, f_r, f_g, f_b;
    logic s_hs, s_vs, s_de, s_fs;
    logic f_hs, f_vs, f_de, f_fs;

    vram_scanout #(
        .H_ACTIVE (20), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (12), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SRC_W (4), .SRC_H (3), .SCALE (2),
        .X_OFS (6), .Y_OFS (3)
    ) u_small (
        .vid_clk     (clk),
        .rst_n       (rst_n),
        .vram        (vif_s.master),
        .pal         (pal),
        .border      (border),
        .out_r       (s_r),
        .out_g       (s_g),
        .out_b       (s_b),
        .out_hsync   (s_hs),
        .out_vsync   (s_vs),
        .out_de      (s_de),
        .frame_start (s_fs)
    );

    vram_scanout u_full (
        .vid_clk     (clk),
        .rst_n       (rst_n),
        .vram        (vif_f.master),
        .pal         (pal),
        .border      (border),
        .out_r       (f_r),
        .out_g       (f_g),
        .out_b       (f_b),
        .out_hsync   (f_hs),
        .out_vsync   (f_vs),
        .out_de      (f_de),
        .frame_start (f_fs)
    );

    // VRAM models: registered read returning sx[1:0].
    always @(posedge clk) vif_s.vramdata <= vif_s.vramaddr[1:0];
    always @(posedge clk) vif_f.vramdata <= vif_f.vramaddr[1:0];

    logic [11:0] s_rgb, f_rgb;
    assign s_rgb = {s_r, s_g, s_b};
    assign f_rgb = {f_r, f_g, f_b};

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic spx(input string tag,
                       input logic [11:0] c,
                       input logic de);
        chk({tag, ".rgb"}, 64'(s_rgb), 64'(c));
        chk({tag, ".de"}, 64'(s_de), 64'(de));
    endtask

    task automatic wait_cyc(input int t);
        int n = 0;
        while (cyc != t && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("wait", 64'(cyc), 64'(t));
    endtask

    function automatic int so(input int f, input int v, input int h);
        return f * SFR + v * SHT + h + 2;
    endfunction

    function automatic int fa(input int v, input int h);
        return v * FHT + h;
    endfunction

    logic stat_en = 1'b0;
    int hs_lo = 0, vs_lo = 0, de_n = 0, fs_n = 0, fs_bad = 0;

    always @(negedge clk) begin
        if (stat_en && rst_n && cyc >= 2 && cyc < 2 + 2 * SFR) begin
            hs_lo <= hs_lo + (s_hs ? 0 : 1);
            vs_lo <= vs_lo + (s_vs ? 0 : 1);
            de_n  <= de_n + (s_de ? 1 : 0);
            if (s_fs) begin
                fs_n <= fs_n + 1;
                if ((cyc - 2) % SFR != 0) fs_bad <= fs_bad + 1;
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        pal    = 48'hFFF_AAA_555_000;
        border = 12'h00F;
        repeat (3) @(negedge clk);
        chk("rst.hs", 64'(s_hs), 64'd1);
        chk("rst.vs", 64'(s_vs), 64'd1);
        spx("rst", 12'h000, 1'b0);
        chk("rst.fs", 64'(s_fs), 64'd0);
        chk("rst.addr", 64'(vif_s.vramaddr), 64'h0);
        chk("rst.f.hs", 64'(f_hs), 64'd1);
        chk("rst.f.de", 64'(f_de), 64'd0);
        @(posedge clk);
        #1 chk("vclk.hi", 64'(vif_s.vramclk), 64'd1);
        @(negedge clk);
        chk("vclk.lo", 64'(vif_s.vramclk), 64'd0);

        rst_n   = 1'b1;
        stat_en = 1'b1;

        wait_cyc(so(0, 0, 0));
        chk("f0.fs", 64'(s_fs), 64'd1);
        chk("f0.hs", 64'(s_hs), 64'd1);
        chk("f0.vs", 64'(s_vs), 64'd1);
        spx("p0_0", 12'h00F, 1'b1);
        wait_cyc(so(0, 0, 1));
        chk("f0.fs1", 64'(s_fs), 64'd0);
        wait_cyc(so(0, 3, 5));
        spx("p3_5", 12'h00F, 1'b1);
        wait_cyc(so(0, 3, 6));
        spx("p3_6", 12'h000, 1'b1);
        wait_cyc(so(0, 3, 8));
        spx("p3_8", 12'h555, 1'b1);
        wait_cyc(so(0, 3, 9));
        spx("p3_9", 12'h555, 1'b1);
        wait_cyc(so(0, 3, 20));
        spx("p3_20", 12'h000, 1'b0);
        chk("p3_20.hs", 64'(s_hs), 64'd1);
        wait_cyc(so(0, 3, 22));
        chk("p3_22.hs", 64'(s_hs), 64'd0);
        wait_cyc(so(0, 3, 25));
        chk("p3_25.hs", 64'(s_hs), 64'd0);
        wait_cyc(so(0, 3, 26));
        chk("p3_26.hs", 64'(s_hs), 64'd1);
        wait_cyc(so(0, 4, 10));
        spx("p4_10", 12'hAAA, 1'b1);
        wait_cyc(so(0, 8, 13));
        spx("p8_13", 12'hFFF, 1'b1);
        wait_cyc(so(0, 8, 14));
        spx("p8_14", 12'h00F, 1'b1);
        wait_cyc(so(0, 9, 12));
        spx("p9_12", 12'h00F, 1'b1);
        wait_cyc(so(0, 12, 0));
        spx("p12_0", 12'h000, 1'b0);
        chk("p12_0.vs", 64'(s_vs), 64'd1);
        wait_cyc(so(0, 13, 0));
        chk("p13_0.vs", 64'(s_vs), 64'd0);
        wait_cyc(so(0, 14, 27));
        chk("p14_27.vs", 64'(s_vs), 64'd0);
        wait_cyc(so(0, 15, 0));
        chk("p15_0.vs", 64'(s_vs), 64'd1);

        wait_cyc(SFR + 4 * SHT + 7);
        chk("a4_7", 64'(vif_s.vramaddr), 64'h0000);
        wait_cyc(SFR + 5 * SHT + 6);
        chk("a5_6", 64'(vif_s.vramaddr), 64'h0100);
        wait_cyc(SFR + 6 * SHT + 12);
        chk("a6_12", 64'(vif_s.vramaddr), 64'h0103);
        wait_cyc(SFR + 8 * SHT + 13);
        chk("a8_13", 64'(vif_s.vramaddr), 64'h0203);
        wait_cyc(SFR + 8 * SHT + 16);
        chk("a8_16", 64'(vif_s.vramaddr), 64'h0203);
        wait_cyc(SFR + 9 * SHT);
        chk("a9_0", 64'(vif_s.vramaddr), 64'h0200);

        wait_cyc(2 + 2 * SFR);
        stat_en = 1'b0;
        chk("hs_lo", 64'(hs_lo), 64'd128);
        chk("vs_lo", 64'(vs_lo), 64'd112);
        chk("de_n", 64'(de_n), 64'd480);
        chk("fs_n", 64'(fs_n), 64'd2);
        chk("fs_bad", 64'(fs_bad), 64'd0);

        wait_cyc(so(2, 5, 0));
        pal    = 48'h123_456_789_ABC;
        border = 12'hF00;
        wait_cyc(so(2, 6, 5));
        spx("old.bd", 12'h00F, 1'b1);
        wait_cyc(so(2, 6, 6));
        spx("old.i0", 12'h000, 1'b1);
        wait_cyc(so(3, 0, 0));
        chk("new.fs", 64'(s_fs), 64'd1);
        spx("new.bd", 12'hF00, 1'b1);
        wait_cyc(so(3, 3, 6));
        spx("new.i0", 12'hABC, 1'b1);
        wait_cyc(so(3, 3, 8));
        spx("new.i1", 12'h789, 1'b1);
        wait_cyc(so(3, 3, 10));
        spx("new.i2", 12'h456, 1'b1);
        wait_cyc(so(3, 3, 12));
        spx("new.i3", 12'h123, 1'b1);

        wait_cyc(fa(24, 80));
        chk("F.a80", 64'(vif_f.vramaddr), 64'h0000);
        wait_cyc(fa(24, 79) + 2);
        chk("F.o79", 64'(f_rgb), 64'h00F);
        wait_cyc(fa(24, 82));
        chk("F.a82", 64'(vif_f.vramaddr), 64'h0000);
        chk("F.o80", 64'(f_rgb), 64'h000);
        chk("F.o80.de", 64'(f_de), 64'd1);
        wait_cyc(fa(24, 83));
        chk("F.a83", 64'(vif_f.vramaddr), 64'h0001);
        wait_cyc(fa(24, 85));
        chk("F.a85", 64'(vif_f.vramaddr), 64'h0001);
        chk("F.o83", 64'(f_rgb), 64'h555);
        wait_cyc(fa(24, 86) + 2);
        chk("F.o86", 64'(f_rgb), 64'hAAA);
        wait_cyc(fa(24, 89) + 2);
        chk("F.o89", 64'(f_rgb), 64'hFFF);
        wait_cyc(fa(24, 557));
        chk("F.a557", 64'(vif_f.vramaddr), 64'h009F);
        wait_cyc(fa(24, 559));
        chk("F.a559", 64'(vif_f.vramaddr), 64'h009F);
        wait_cyc(fa(24, 560) + 2);
        chk("F.o560", 64'(f_rgb), 64'h00F);
        wait_cyc(fa(24, 640) + 2);
        chk("F.o640", 64'(f_rgb), 64'h000);
        chk("F.o640.de", 64'(f_de), 64'd0);
        wait_cyc(fa(24, 655) + 2);
        chk("F.hs655", 64'(f_hs), 64'd1);
        wait_cyc(fa(24, 656) + 2);
        chk("F.hs656", 64'(f_hs), 64'd0);
        wait_cyc(fa(24, 751) + 2);
        chk("F.hs751", 64'(f_hs), 64'd0);
        wait_cyc(fa(24, 752) + 2);
        chk("F.hs752", 64'(f_hs), 64'd1);
        wait_cyc(fa(26, 559));
        chk("F.a26", 64'(vif_f.vramaddr), 64'h009F);
        wait_cyc(fa(27, 80));
        chk("F.a27", 64'(vif_f.vramaddr), 64'h0100);

        wait_cyc(50 * SFR + 5 * SHT + 10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr.hs", 64'(s_hs), 64'd1);
        chk("mr.vs", 64'(s_vs), 64'd1);
        spx("mr", 12'h000, 1'b0);
        chk("mr.fs", 64'(s_fs), 64'd0);
        chk("mr.addr", 64'(vif_s.vramaddr), 64'h0);
        chk("mr.f.de", 64'(f_de), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);
        chk("rel1.fs", 64'(s_fs), 64'd0);
        spx("rel1", 12'h000, 1'b0);
        wait_cyc(2);
        chk("rel2.fs", 64'(s_fs), 64'd1);
        spx("rel2", 12'hF00, 1'b1);
        wait_cyc(3);
        chk("rel3.fs", 64'(s_fs), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
